// File: rtl/objective.sv
// Training terminus: pairs a forward activation with a target and returns the signed
// error backward, forwarding the activation. Optional MSE loss reporting under LOSS_EN.
module objective #(
  parameter int WIDTH = 8,
  parameter int BATCH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               train,
  input  logic               input_forward_valid,
  input  logic [WIDTH-1:0]   input_forward_data,
  output logic               input_forward_ready,
  input  logic               input_target_valid,
  input  logic [WIDTH-1:0]   input_target_data,
  output logic               input_target_ready,
  output logic               output_backward_valid,
  output logic [2*WIDTH-1:0] output_backward_data,
  input  logic               output_backward_ready,
  output logic               output_forward_valid,
  output logic [WIDTH-1:0]   output_forward_data,
  input  logic               output_forward_ready
`ifdef LOSS_EN
  ,
  output logic               output_loss_valid,
  output logic [2*WIDTH-1:0] output_loss_data,
  input  logic               output_loss_ready
`endif
);

  typedef enum logic [1:0] {LOAD, COMP, EMIT} state_t;

  state_t             state, state_nxt;
  logic               act_held, tgt_held, mode;
  logic [WIDTH-1:0]   act_q, tgt_q;
  logic               mode_eff, fwd_hs, tgt_hs, emit_done, loss_stall;
  logic signed [2*WIDTH-1:0] err;

  // Before the activation arrives, the live train input decides whether a target is wanted.
  assign mode_eff            = act_held ? mode : train;
  assign input_forward_ready = (state == LOAD) & !act_held;
  assign input_target_ready  = (state == LOAD) & !tgt_held & mode_eff;
  assign fwd_hs              = input_forward_valid & input_forward_ready;
  assign tgt_hs              = input_target_valid & input_target_ready;

  assign err = $signed({{WIDTH{1'b0}}, tgt_q}) - $signed({{WIDTH{1'b0}}, act_q});

  assign emit_done = (!output_forward_valid  | output_forward_ready) &
                     (!output_backward_valid | output_backward_ready);

`ifdef LOSS_EN
  localparam int CW = $clog2(BATCH);

  logic [2*WIDTH+CW-1:0] acc, acc_sum;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      mag;
  logic [2*WIDTH-1:0]    sq_full, sq;

  // |err| never exceeds 2^WIDTH-1, so squaring the magnitude needs only 2*WIDTH bits.
  assign mag     = WIDTH'(err[2*WIDTH-1] ? -err : err);
  assign sq_full = {{WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, mag};
  assign sq      = sq_full >> WIDTH;
  assign acc_sum = acc + (2*WIDTH+CW)'(sq);

  assign loss_stall = mode & (cnt == CW'(BATCH-1)) & output_loss_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc               <= '0;
      cnt               <= '0;
      output_loss_valid <= 1'b0;
      output_loss_data  <= '0;
    end else begin
      if (output_loss_valid && output_loss_ready) output_loss_valid <= 1'b0;
      if (state == COMP && !loss_stall && mode) begin
        if (cnt == CW'(BATCH-1)) begin
          output_loss_data  <= (2*WIDTH)'(acc_sum >> CW);
          output_loss_valid <= 1'b1;
          acc               <= '0;
          cnt               <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
`else
  assign loss_stall = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (act_held && (tgt_held || !mode)) state_nxt = COMP;
      COMP:    if (!loss_stall) state_nxt = EMIT;
      EMIT:    if (emit_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= LOAD;
      act_held              <= 1'b0;
      tgt_held              <= 1'b0;
      mode                  <= 1'b0;
      act_q                 <= '0;
      tgt_q                 <= '0;
      output_forward_valid  <= 1'b0;
      output_forward_data   <= '0;
      output_backward_valid <= 1'b0;
      output_backward_data  <= '0;
    end else begin
      state <= state_nxt;
      if (fwd_hs) begin
        act_held <= 1'b1;
        act_q    <= input_forward_data;
        mode     <= train;
      end
      if (tgt_hs) begin
        tgt_held <= 1'b1;
        tgt_q    <= input_target_data;
      end
      if (state == COMP && !loss_stall) begin
        output_forward_valid  <= 1'b1;
        output_forward_data   <= act_q;
        output_backward_valid <= mode;
        output_backward_data  <= err;
      end
      if (state == EMIT) begin
        if (output_forward_ready)  output_forward_valid  <= 1'b0;
        if (output_backward_ready) output_backward_valid <= 1'b0;
        // An inference sample leaves any early target in place for the next one.
        if (emit_done) begin
          act_held <= 1'b0;
          if (mode) tgt_held <= 1'b0;
        end
      end
    end
  end

endmodule
